// File: rtl/squash_input_ctrl.sv
// Player-input front end for the solo_squash core: debounces the four buttons and
// applies pause / new-game requests only on a frame boundary (falling vsync_n).
`timescale 1ns/1ps

module squash_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int NEWGAME_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pause,
    input  logic       key_new_game,
    input  logic       key_down,
    input  logic       key_up,
    input  logic       vsync_n,
    output logic       pause_n,
    output logic       new_game_n,
    output logic       down_key_n,
    output logic       up_key_n,
    output logic       paused,
    output logic [1:0] state_dbg
);

    localparam int NKEYS      = 4;
    localparam int K_PAUSE    = 0;
    localparam int K_NEW_GAME = 1;
    localparam int K_DOWN     = 2;
    localparam int K_UP       = 3;
    localparam int FRM_W      = $clog2(NEWGAME_FRAMES + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LOAD = FRM_W'(NEWGAME_FRAMES);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSED  = 2'd1,
        NEWGAME = 2'd2
    } state_t;

    logic [NKEYS-1:0] raw;
    logic [NKEYS-1:0] deb;
    logic [NKEYS-1:0] deb_prev;
    logic [CNT_W-1:0] deb_cnt [NKEYS];

    logic             vs_q;
    logic             frame_tick;
    logic             pause_rise;
    logic             ng_rise;
    logic             pause_req;
    logic             ng_req;
    logic [FRM_W-1:0] frame_cnt;
    logic             keys_enabled;
    state_t           state;

    assign raw = {key_up, key_down, key_new_game, key_pause};

    // A key change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < NKEYS; i++) begin
                if (raw[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign pause_rise = deb[K_PAUSE] & ~deb_prev[K_PAUSE];
    assign ng_rise    = deb[K_NEW_GAME] & ~deb_prev[K_NEW_GAME];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vsync_n;
        end
    end

    assign frame_tick   = vs_q & ~vsync_n;
    assign keys_enabled = (state == RUN) && !(deb[K_DOWN] && deb[K_UP]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            pause_req  <= 1'b0;
            ng_req     <= 1'b0;
            frame_cnt  <= '0;
            pause_n    <= 1'b1;
            new_game_n <= 1'b1;
            down_key_n <= 1'b1;
            up_key_n   <= 1'b1;
            paused     <= 1'b0;
            state_dbg  <= 2'd0;
        end else begin
            if (frame_tick) begin
                if (ng_req) begin
                    state     <= NEWGAME;
                    frame_cnt <= FRM_LOAD;
                    ng_req    <= 1'b0;
                    pause_req <= 1'b0;
                end else begin
                    case (state)
                        RUN: begin
                            if (pause_req) begin
                                state     <= PAUSED;
                                pause_req <= 1'b0;
                            end
                        end
                        PAUSED: begin
                            if (pause_req) begin
                                state     <= RUN;
                                pause_req <= 1'b0;
                            end
                        end
                        NEWGAME: begin
                            if (frame_cnt <= FRM_ONE) begin
                                state     <= RUN;
                                frame_cnt <= '0;
                                pause_req <= 1'b0;
                            end else begin
                                frame_cnt <= frame_cnt - FRM_ONE;
                            end
                        end
                        default: state <= RUN;
                    endcase
                end
            end

            // NOTE: with non-blocking assignments the last one in the block wins, so a
            // press landing on the same edge as a consuming tick stays pending.
            if (pause_rise) pause_req <= 1'b1;
            if (ng_rise)    ng_req    <= 1'b1;

            pause_n    <= (state != PAUSED);
            new_game_n <= (state != NEWGAME);
            paused     <= (state == PAUSED);
            state_dbg  <= state;
            down_key_n <= !(keys_enabled && deb[K_DOWN]);
            up_key_n   <= !(keys_enabled && deb[K_UP]);
        end
    end

endmodule

// File: tb/tb_squash_input_ctrl.sv
// Self-checking bench for squash_input_ctrl with a short debounce window; expected
// output words are queued as stimulus is driven and compared when sampled.
`timescale 1ns/1ps

module tb_squash_input_ctrl;

    localparam int DEB = 4;

    typedef struct packed {
        logic       pause_n;
        logic       new_game_n;
        logic       down_key_n;
        logic       up_key_n;
        logic       paused;
        logic [1:0] state;
    } out_t;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       key_pause    = 1'b0;
    logic       key_new_game = 1'b0;
    logic       key_down     = 1'b0;
    logic       key_up       = 1'b0;
    logic       vsync_n      = 1'b1;
    logic       pause_n;
    logic       new_game_n;
    logic       down_key_n;
    logic       up_key_n;
    logic       paused;
    logic [1:0] state_dbg;

    out_t obs;
    out_t exp_v;
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    squash_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(3),
        .NEWGAME_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_pause(key_pause),
        .key_new_game(key_new_game),
        .key_down(key_down),
        .key_up(key_up),
        .vsync_n(vsync_n),
        .pause_n(pause_n),
        .new_game_n(new_game_n),
        .down_key_n(down_key_n),
        .up_key_n(up_key_n),
        .paused(paused),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {pause_n, new_game_n, down_key_n, up_key_n, paused, state_dbg};

    function automatic out_t mk(input logic pn, input logic ngn, input logic dn,
                                input logic un, input logic p, input logic [1:0] s);
        return {pn, ngn, dn, un, p, s};
    endfunction

    // Output words in the states the scenarios visit.
    out_t IDLE, RUN_UP, PAUSE_O, NG_O;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with vsync_n high: one falling edge, tick acts at the next posedge.
    task automatic pulse_vsync();
        vsync_n = 1'b0;
        @(negedge clk);
        vsync_n = 1'b1;
    endtask

    task automatic press_release_pause();
        key_pause = 1'b1;
        cycles(DEB + 2);
        key_pause = 1'b0;
        cycles(DEB + 2);
    endtask

    task automatic test_reset();
        key_pause = 1'b1; key_new_game = 1'b1; key_down = 1'b1; key_up = 1'b1;
        exp_q.push_back(IDLE);
        cycles(3);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL reset_hold: got %b expected %b", obs, exp_v); end

        key_pause = 1'b0; key_new_game = 1'b0; key_down = 1'b0; key_up = 1'b0;
        rst_n = 1'b1;
        exp_q.push_back(IDLE);
        cycles(10);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL reset_release_run: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_debounce();
        key_up = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(IDLE);
        cycles(DEB - 1);
        key_up = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            exp_v = exp_q.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL short_glitch[%0d]: got %b expected %b", i, obs, exp_v); end
        end

        key_up = 1'b1;
        exp_q.push_back(IDLE);
        exp_q.push_back(RUN_UP);
        cycles(DEB);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL up_before_deb: got %b expected %b", obs, exp_v); end
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL up_after_deb: got %b expected %b", obs, exp_v); end

        key_down = 1'b1;
        exp_q.push_back(RUN_UP);
        exp_q.push_back(IDLE);
        cycles(DEB);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL down_before_deb: got %b expected %b", obs, exp_v); end
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL both_keys_block: got %b expected %b", obs, exp_v); end

        key_down = 1'b0;
        exp_q.push_back(RUN_UP);
        cycles(DEB + 1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL down_released: got %b expected %b", obs, exp_v); end

        key_up = 1'b0;
        exp_q.push_back(IDLE);
        cycles(DEB + 1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL up_released: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_pause_toggle();
        key_up = 1'b1;
        cycles(DEB + 2);
        press_release_pause();
        exp_q.push_back(RUN_UP);
        exp_q.push_back(PAUSE_O);
        pulse_vsync();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL pause_output_lag: got %b expected %b", obs, exp_v); end
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL pause_entered: got %b expected %b", obs, exp_v); end

        press_release_pause();
        exp_q.push_back(RUN_UP);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL pause_left: got %b expected %b", obs, exp_v); end

        key_up = 1'b0;
        cycles(DEB + 2);
    endtask

    task automatic test_newgame_priority();
        key_pause = 1'b1; key_new_game = 1'b1;
        cycles(DEB + 2);
        key_pause = 1'b0; key_new_game = 1'b0;
        cycles(DEB + 2);
        exp_q.push_back(NG_O);
        exp_q.push_back(NG_O);
        exp_q.push_back(NG_O);
        exp_q.push_back(IDLE);
        exp_q.push_back(IDLE);

        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL ng_enter: got %b expected %b", obs, exp_v); end
        cycles(2);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL ng_second_frame: got %b expected %b", obs, exp_v); end
        pulse_vsync();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL ng_exit_lag: got %b expected %b", obs, exp_v); end
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL ng_exit: got %b expected %b", obs, exp_v); end
        cycles(2);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL ng_pause_cleared: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_newgame_discard();
        key_new_game = 1'b1;
        cycles(DEB + 2);
        key_new_game = 1'b0;
        cycles(DEB + 2);
        exp_q.push_back(NG_O);
        exp_q.push_back(IDLE);
        exp_q.push_back(IDLE);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL discard_enter: got %b expected %b", obs, exp_v); end

        press_release_pause();
        pulse_vsync();
        cycles(1);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL discard_exit: got %b expected %b", obs, exp_v); end
        cycles(2);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL discard_pause_dropped: got %b expected %b", obs, exp_v); end
    endtask

    // The press event is raised during the very cycle the frame tick is high.
    task automatic test_same_cycle();
        key_pause = 1'b1;
        exp_q.push_back(IDLE);
        exp_q.push_back(PAUSE_O);
        exp_q.push_back(IDLE);
        cycles(DEB);
        vsync_n = 1'b0;
        cycles(1);
        vsync_n = 1'b1;
        key_pause = 1'b0;
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL same_cycle_no_change: got %b expected %b", obs, exp_v); end

        cycles(DEB + 2);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL same_cycle_next_tick: got %b expected %b", obs, exp_v); end

        press_release_pause();
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL same_cycle_resume: got %b expected %b", obs, exp_v); end
    endtask

    // Enter NEWGAME with a fresh pause request landing on the entry edge, then reset.
    task automatic test_reset_mid_newgame();
        key_new_game = 1'b1;
        cycles(DEB + 2);
        key_new_game = 1'b0;
        cycles(DEB + 2);
        exp_q.push_back(NG_O);
        exp_q.push_back(IDLE);
        exp_q.push_back(IDLE);

        key_pause = 1'b1;
        cycles(DEB);
        vsync_n = 1'b0;
        cycles(1);
        vsync_n = 1'b1;
        key_pause = 1'b0;
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL ng_before_reset: got %b expected %b", obs, exp_v); end

        rst_n = 1'b0;
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL reset_mid_ng: got %b expected %b", obs, exp_v); end

        rst_n = 1'b1;
        cycles(3);
        pulse_vsync();
        cycles(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL no_residual_after_reset: got %b expected %b", obs, exp_v); end
    endtask

    initial begin
        IDLE    = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        RUN_UP  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        PAUSE_O = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
        NG_O    = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);

        test_reset();
        test_debounce();
        test_pause_toggle();
        test_newgame_priority();
        test_newgame_discard();
        test_same_cycle();
        test_reset_mid_newgame();

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
